// File: rtl/mc_main_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_main_ctrl_if
//
// Bundle between the multi-cycle main control FSM and the MIPS datapath.
//
// Signals
//   opcode        [5:0] instr[31:26] from the instruction register (to ctrl)
//   mem_ready           memory completes the current access this cycle (to ctrl)
//   pc_write            unconditional PC load
//   pc_write_cond       PC load qualified by the ALU zero flag
//   pc_src        [1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d              memory address select, 0 PC, 1 ALUOut
//   mem_read            memory read request
//   mem_write           memory write request
//   ir_write            instruction register load
//   mem_to_reg          write-back data select, 1 MDR, 0 ALUOut
//   reg_dst             destination select, 1 rd, 0 rt
//   reg_write           register-file write enable
//   alu_src_a           ALU A operand, 0 PC, 1 register A
//   alu_src_b     [1:0] ALU B operand, 00 B, 01 const 4, 10 sext imm, 11 imm<<2
//   alu_ct_op     [1:0] ALU control class, 00 add, 01 sub, 10 decode funct
//   instr_done          one-cycle pulse in the last cycle of an instruction
//   exc_illegal         sticky unsupported-opcode flag
//   state         [3:0] current FSM state code (debug)
//
// Handshake: mem_ready is a ready-only completion strobe. The controller holds
// its request (mem_read or mem_write plus i_or_d) stable for as long as
// mem_ready is low; the access completes in the first cycle mem_ready is high,
// and only FETCH, MEMRD and MEMWR look at it.
//
// Modports
//   master : the control FSM (drives strobes, samples opcode / mem_ready)
//   slave  : the datapath / memory side
// -----------------------------------------------------------------------------
interface mc_main_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ct_op;
    logic       instr_done;
    logic       exc_illegal;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_ct_op, instr_done, exc_illegal, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
               alu_src_b, alu_ct_op, instr_done, exc_illegal, state
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// -----------------------------------------------------------------------------
// mc_main_ctrl
//
// Multi-cycle main control FSM for the MIPS core. One instruction at a time is
// walked through fetch, decode, execute, memory and write-back; every cycle
// the datapath strobes and mux selects are a Moore decode of the state, with
// the single exception of the memory-completion gating in FETCH / MEMRD /
// MEMWR, which follows mem_ready combinationally.
//
// Ports
//   clk    rising-edge core clock
//   rst_n  asynchronous active-low reset; forces state RESET (all outputs 0)
//   bus    mc_main_ctrl_if.master, see the interface header for the signals
// -----------------------------------------------------------------------------
module mc_main_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    mc_main_ctrl_if.master    bus
);

    // State codes are part of the debug contract and must not be renumbered.
    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:       state_d = S_MEMADR;
                    OP_RTYPE:           state_d = S_EXEC;
                    OP_BEQ:             state_d = S_BRANCH;
                    OP_J:               state_d = S_JUMP;
                    OP_ADDI, OP_ADDIU:  state_d = S_ADDIEX;
                    default:            state_d = S_TRAP;
                endcase
            end

            // The IR is stable across the instruction, so the opcode can be
            // looked at again here rather than remembering the DECODE result.
            // Anything other than lw/sw cannot legally reach MEMADR; trap it
            // instead of guessing an access direction.
            S_MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_TRAP;
                end
            end

            S_MEMRD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: state_d = S_FETCH;

            S_MEMWR: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;

            // Only reset leaves TRAP.
            S_TRAP:   state_d = S_TRAP;

            // Codes 14 and 15 are unreachable; recover through RESET.
            default:  state_d = S_RESET;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode. Everything defaults to 0 so a state only lists what it
    // asserts; RESET, TRAP and the unreachable codes therefore drive no
    // strobes at all.
    // -------------------------------------------------------------------------
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 2'b00;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_ct_op     = 2'b00;
        bus.instr_done    = 1'b0;

        case (state_q)
            // PC + 4 is computed every FETCH cycle, but the PC and IR only
            // load in the cycle the memory actually returns the instruction.
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end

            // Speculatively compute the branch target into ALUOut.
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
            end

            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end

            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end

            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end

            // A store retires in the cycle its write completes.
            S_MEMWR: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end

            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ct_op = 2'b10;
            end

            S_ALUWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end

            // Subtract A - B; the PC loads ALUOut (target from DECODE) only
            // when the zero flag qualifies pc_write_cond.
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_ct_op     = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'b01;
                bus.instr_done    = 1'b1;
            end

            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src     = 2'b10;
                bus.instr_done = 1'b1;
            end

            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end

            S_ADDIWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end

            default: begin
            end
        endcase
    end

    // TRAP is only left through reset, so the flag is sticky by construction.
    assign bus.exc_illegal = (state_q == S_TRAP);
    assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_main_ctrl
//
// Directed bench for mc_main_ctrl. The driver applies opcode / mem_ready one
// cycle at a time and pushes the hand-written output vector expected in that
// cycle; a monitor pops and compares on the falling edge. While reset is
// asserted the monitor checks the all-zero RESET vector instead.
// -----------------------------------------------------------------------------
module tb_mc_main_ctrl;

    // Vector layout (MSB..LSB):
    //   state[3:0] pc_write pc_write_cond pc_src[1:0] i_or_d mem_read
    //   mem_write ir_write mem_to_reg reg_dst reg_write alu_src_a
    //   alu_src_b[1:0] alu_ct_op[1:0] instr_done exc_illegal
    localparam int W = 22;
    //                                 st    pcw   pcwc  pcs    iord  mrd   mwr   irw   m2r   rdst  rw    asa   asb    aop    done  exc
    localparam logic [W-1:0] V_RESET   = {4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [W-1:0] V_FETCH_R = {4'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [W-1:0] V_FETCH_W = {4'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [W-1:0] V_DECODE  = {4'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0};
    localparam logic [W-1:0] V_MEMADR  = {4'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [W-1:0] V_MEMRD   = {4'd4, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [W-1:0] V_MEMWB   = {4'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [W-1:0] V_MEMWR_R = {4'd6, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [W-1:0] V_MEMWR_W = {4'd6, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [W-1:0] V_EXEC    = {4'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam logic [W-1:0] V_ALUWB   = {4'd8, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [W-1:0] V_BRANCH  = {4'd9, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam logic [W-1:0] V_JUMP    = {4'd10,1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [W-1:0] V_ADDIEX  = {4'd11,1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [W-1:0] V_ADDIWB  = {4'd12,1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [W-1:0] V_TRAP    = {4'd13,1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1};

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ILL   = 6'b111111;

    localparam int EXP_RETIRED = 8;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mc_main_ctrl_if bus ();

    mc_main_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [W-1:0] act;
    assign act = {bus.state, bus.pc_write, bus.pc_write_cond, bus.pc_src,
                  bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                  bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.alu_ct_op, bus.instr_done,
                  bus.exc_illegal};

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks   = 0;
    int           n_errors   = 0;
    int           n_done     = 0;
    logic         finish_req = 1'b0;

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    // One cycle: inputs for the cycle starting at this rising edge, plus the
    // outputs the controller must show during that cycle.
    task automatic step(input logic [5:0] op, input logic rdy,
                        input logic [W-1:0] exp, input string tag);
        @(posedge clk);
        #1;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Reset lands between clock edges so its asynchronous effect is visible.
    task automatic pulse_reset(input int cycles);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #3;
        bus.mem_ready = 1'b1;
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bus.opcode    = OP_RTYPE;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        // lw, no waits: 5 cycles
        step(OP_LW, 1'b1, V_FETCH_R, "lw_fetch");
        step(OP_LW, 1'b1, V_DECODE,  "lw_decode");
        step(OP_LW, 1'b1, V_MEMADR,  "lw_memadr");
        step(OP_LW, 1'b1, V_MEMRD,   "lw_memrd");
        step(OP_LW, 1'b1, V_MEMWB,   "lw_memwb");

        // R-type: 4 cycles
        step(OP_RTYPE, 1'b1, V_FETCH_R, "r_fetch");
        step(OP_RTYPE, 1'b1, V_DECODE,  "r_decode");
        step(OP_RTYPE, 1'b1, V_EXEC,    "r_exec");
        step(OP_RTYPE, 1'b1, V_ALUWB,   "r_aluwb");

        // beq: 3 cycles
        step(OP_BEQ, 1'b1, V_FETCH_R, "beq_fetch");
        step(OP_BEQ, 1'b1, V_DECODE,  "beq_decode");
        step(OP_BEQ, 1'b1, V_BRANCH,  "beq_branch");

        // j: 3 cycles
        step(OP_J, 1'b1, V_FETCH_R, "j_fetch");
        step(OP_J, 1'b1, V_DECODE,  "j_decode");
        step(OP_J, 1'b1, V_JUMP,    "j_jump");

        // sw with 2 FETCH waits and 3 MEMWR waits: 9 cycles
        step(OP_SW, 1'b0, V_FETCH_W, "sw_fetch_wait0");
        step(OP_SW, 1'b0, V_FETCH_W, "sw_fetch_wait1");
        step(OP_SW, 1'b1, V_FETCH_R, "sw_fetch");
        step(OP_SW, 1'b1, V_DECODE,  "sw_decode");
        step(OP_SW, 1'b1, V_MEMADR,  "sw_memadr");
        for (int i = 0; i < 3; i++) begin
            step(OP_SW, 1'b0, V_MEMWR_W, "sw_memwr_wait");
        end
        step(OP_SW, 1'b1, V_MEMWR_R, "sw_memwr");

        // addiu with mem_ready low where it must be ignored
        step(OP_ADDIU, 1'b1, V_FETCH_R, "addiu_fetch");
        step(OP_ADDIU, 1'b0, V_DECODE,  "addiu_decode");
        step(OP_ADDIU, 1'b0, V_ADDIEX,  "addiu_addiex");
        step(OP_ADDIU, 1'b0, V_ADDIWB,  "addiu_addiwb");

        // addi
        step(OP_ADDI, 1'b1, V_FETCH_R, "addi_fetch");
        step(OP_ADDI, 1'b1, V_DECODE,  "addi_decode");
        step(OP_ADDI, 1'b1, V_ADDIEX,  "addi_addiex");
        step(OP_ADDI, 1'b1, V_ADDIWB,  "addi_addiwb");

        // lw interrupted by reset while MEMRD waits; it must not retire
        step(OP_LW, 1'b1, V_FETCH_R, "lw2_fetch");
        step(OP_LW, 1'b1, V_DECODE,  "lw2_decode");
        step(OP_LW, 1'b1, V_MEMADR,  "lw2_memadr");
        step(OP_LW, 1'b0, V_MEMRD,   "lw2_memrd_wait");
        pulse_reset(2);
        step(OP_LW, 1'b1, V_FETCH_R, "post_reset_fetch");
        step(OP_ILL, 1'b1, V_DECODE, "ill_decode");

        // illegal opcode: TRAP held, mem_ready toggling must not matter
        for (int i = 0; i < 20; i++) begin
            step(OP_ILL, logic'(i % 2), V_TRAP, "trap_hold");
        end
        pulse_reset(1);

        // trap cleared by reset; a j retires normally afterwards
        step(OP_J, 1'b1, V_FETCH_R, "j2_fetch");
        step(OP_J, 1'b1, V_DECODE,  "j2_decode");
        step(OP_J, 1'b1, V_JUMP,    "j2_jump");
        finish_req = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin
        logic [W-1:0] exp;
        string        tag;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                n_checks++;
                if (act !== exp) begin
                    n_errors++;
                    $display("FAIL %s: got %h expected %h (state %0d)",
                             tag, act, exp, act[W-1 -: 4]);
                end
                if (act[1] === 1'b1) begin
                    n_done++;
                end
            end else if (!rst_n) begin
                n_checks++;
                if (act !== V_RESET) begin
                    n_errors++;
                    $display("FAIL in_reset: got %h expected %h", act, V_RESET);
                end
            end
            if (finish_req && exp_q.size() == 0) begin
                n_checks++;
                if (n_done != EXP_RETIRED) begin
                    n_errors++;
                    $display("FAIL retired_count: got %0d expected %0d",
                             n_done, EXP_RETIRED);
                end
                $display("Simulation finished: %0d checks, %0d errors",
                         n_checks, n_errors);
                $finish;
            end
        end
    end

    // Bound on the whole run in case the stimulus stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
